mvb_manchester_tx: RTL and testbench

- Transmit-side Manchester encoder for the MVB link, running at 24 MHz with 16 clocks per bit (1.5 Mbit/s).
- Takes a parallel data word on a start strobe and serialises a full frame onto the line: start delimiter, data MSB first, end delimiter.
- Sits directly upstream of the Manchester receive decoder and drives the bus transceiver (data plus output enable).
- Its bit encoding is the one the receive decoder accepts: first half high, second half low = '1'.

---
 rtl/mvb_manchester_tx_pkg.sv | 27 ++
 rtl/mvb_manchester_tx_if.sv | 23 ++
 rtl/mvb_manchester_tx_symbol_gen.sv | 29 ++
 rtl/mvb_manchester_tx.sv | 129 ++++++++++++
 tb/tb_mvb_manchester_tx.sv | 179 +++++++++++++++++
 5 files changed

// File: rtl/mvb_manchester_tx_pkg.sv
// Shared types and constants for the MVB Manchester transmit path.
package mvb_pkg;

    localparam int DATA_W_DEF   = 16;
    localparam int BIT_CLKS_DEF = 16;
    localparam int DELIM_LEN    = 9;

    typedef enum logic [1:0] {
        SYM_ONE  = 2'd0,
        SYM_ZERO = 2'd1,
        SYM_NH   = 2'd2,
        SYM_NL   = 2'd3
    } sym_e;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DELIM = 2'd1,
        DATA  = 2'd2,
        END   = 2'd3
    } state_e;

    // Master-frame start delimiter; the leading ONE doubles as the start bit.
    localparam sym_e START_DELIM [DELIM_LEN] = '{
        SYM_ONE, SYM_NH, SYM_NL, SYM_ZERO, SYM_NH, SYM_NL, SYM_ZERO, SYM_ZERO, SYM_ZERO
    };

endpackage

// File: rtl/mvb_manchester_tx_if.sv
// Frame request handshake and line-side outputs of the Manchester transmitter.
interface mvb_manchester_tx_if #(
    parameter int DATA_W = 16
) ();

    logic              tx_start;
    logic [DATA_W-1:0] tx_data;
    logic              tx_busy;
    logic              tx_done;
    logic              line_out;
    logic              line_oe;

    modport master (
        output tx_start, tx_data,
        input  tx_busy, tx_done, line_out, line_oe
    );

    modport slave (
        input  tx_start, tx_data,
        output tx_busy, tx_done, line_out, line_oe
    );

endinterface

// File: rtl/mvb_manchester_tx_symbol_gen.sv
// Maps a line symbol and its phase within the bit time to a Manchester level.
module mvb_symbol_gen
    import mvb_pkg::*;
#(
    parameter  int BIT_CLKS = BIT_CLKS_DEF,
    localparam int PH_W     = $clog2(BIT_CLKS)
) (
    input  sym_e            sym,
    input  logic [PH_W-1:0] phase,
    output logic            level
);

    logic first_half_s;

    assign first_half_s = (phase < PH_W'(BIT_CLKS / 2));

    // Symbol-to-level decode
    always_comb begin
        level = 1'b0;
        case (sym)
            SYM_ONE:  level = first_half_s;
            SYM_ZERO: level = ~first_half_s;
            SYM_NH:   level = 1'b1;
            SYM_NL:   level = 1'b0;
            default:  level = 1'b0;
        endcase
    end

endmodule

// File: rtl/mvb_manchester_tx.sv
// MVB master-frame Manchester transmitter: start delimiter, data MSB first, NL end delimiter.
module mvb_manchester_tx
    import mvb_pkg::*;
#(
    parameter int DATA_W   = DATA_W_DEF,
    parameter int BIT_CLKS = BIT_CLKS_DEF
) (
    input  logic                 clk_24M,
    input  logic                 rst,
    mvb_manchester_tx_if.slave   bus
);

    localparam int PH_W  = $clog2(BIT_CLKS);
    localparam int CNT_W = 6;

    state_e            state_r, state_s;
    logic [PH_W-1:0]   phase_r, phase_s;
    logic [CNT_W-1:0]  cnt_r, cnt_s;
    logic [DATA_W-1:0] shift_r, shift_s;
    sym_e              sym_s;
    logic              level_s;
    logic              last_phase_s;
    logic              line_out_r, line_oe_r, tx_busy_r, tx_done_r;

    assign last_phase_s = (phase_r == PH_W'(BIT_CLKS - 1));

    // Next-state, counters and the symbol for the upcoming cycle
    always_comb begin
        state_s = state_r;
        phase_s = phase_r + PH_W'(1);
        cnt_s   = cnt_r;
        shift_s = shift_r;
        case (state_r)
            IDLE: begin
                phase_s = {PH_W{1'b0}};
                cnt_s   = {CNT_W{1'b0}};
                if (bus.tx_start) begin
                    state_s = DELIM;
                    shift_s = bus.tx_data;
                end else begin
                    state_s = IDLE;
                end
            end
            DELIM: begin
                if (last_phase_s) begin
                    if (cnt_r == CNT_W'(DELIM_LEN - 1)) begin
                        state_s = DATA;
                        cnt_s   = {CNT_W{1'b0}};
                    end else begin
                        cnt_s = cnt_r + CNT_W'(1);
                    end
                end else begin
                    cnt_s = cnt_r;
                end
            end
            DATA: begin
                if (last_phase_s) begin
                    shift_s = {shift_r[DATA_W-2:0], 1'b0};
                    if (cnt_r == CNT_W'(DATA_W - 1)) begin
                        state_s = END;
                        cnt_s   = {CNT_W{1'b0}};
                    end else begin
                        cnt_s = cnt_r + CNT_W'(1);
                    end
                end else begin
                    shift_s = shift_r;
                end
            end
            END: begin
                if (last_phase_s) begin
                    state_s = IDLE;
                    phase_s = {PH_W{1'b0}};
                end else begin
                    state_s = END;
                end
            end
            default: begin
                state_s = IDLE;
                phase_s = {PH_W{1'b0}};
                cnt_s   = {CNT_W{1'b0}};
            end
        endcase

        // Outputs are registered, so the level is computed for the state being entered
        sym_s = SYM_NL;
        case (state_s)
            DELIM:   sym_s = START_DELIM[cnt_s[3:0]];
            DATA:    sym_s = shift_s[DATA_W-1] ? SYM_ONE : SYM_ZERO;
            END:     sym_s = SYM_NL;
            IDLE:    sym_s = SYM_NL;
            default: sym_s = SYM_NL;
        endcase
    end

    mvb_symbol_gen #(.BIT_CLKS(BIT_CLKS)) u_symbol_gen (
        .sym   (sym_s),
        .phase (phase_s),
        .level (level_s)
    );

    // State, counters and registered line/handshake outputs
    always_ff @(posedge clk_24M or posedge rst) begin
        if (rst) begin
            state_r    <= IDLE;
            phase_r    <= {PH_W{1'b0}};
            cnt_r      <= {CNT_W{1'b0}};
            shift_r    <= {DATA_W{1'b0}};
            line_out_r <= 1'b0;
            line_oe_r  <= 1'b0;
            tx_busy_r  <= 1'b0;
            tx_done_r  <= 1'b0;
        end else begin
            state_r    <= state_s;
            phase_r    <= phase_s;
            cnt_r      <= cnt_s;
            shift_r    <= shift_s;
            line_out_r <= (state_s != IDLE) & level_s;
            line_oe_r  <= (state_s != IDLE);
            tx_busy_r  <= (state_s != IDLE);
            tx_done_r  <= (state_r != IDLE) && (state_s == IDLE);
        end
    end

    assign bus.line_out = line_out_r;
    assign bus.line_oe  = line_oe_r;
    assign bus.tx_busy  = tx_busy_r;
    assign bus.tx_done  = tx_done_r;

endmodule

// File: tb/tb_mvb_manchester_tx.sv
// Directed bench for mvb_manchester_tx: per-cycle expected line state queued on each accepted start.
module tb_mvb_manchester_tx;

    localparam int DW = 16;
    localparam int BC = 16;

    logic clk_24M = 1'b0;
    logic rst     = 1'b1;

    always #21 clk_24M = ~clk_24M;

    mvb_manchester_tx_if #(.DATA_W(DW)) bus ();

    mvb_manchester_tx #(.DATA_W(DW), .BIT_CLKS(BC)) dut (
        .clk_24M (clk_24M),
        .rst     (rst),
        .bus     (bus)
    );

    // Expected {line_oe, line_out, tx_busy, tx_done} per cycle
    logic [3:0] exp_q [$];
    logic       line_samp [$];
    int         errors = 0;
    int         checks = 0;
    string      tag = "reset";

    // Half-bit levels {first, second} of the start delimiter symbols
    logic [1:0] delim_tb [9] = '{2'b10, 2'b11, 2'b00, 2'b01, 2'b11, 2'b00, 2'b01, 2'b01, 2'b01};

    function automatic logic [3:0] observed();
        return {bus.line_oe, bus.line_out, bus.tx_busy, bus.tx_done};
    endfunction

    task automatic push_frame(input logic [DW-1:0] d);
        logic [1:0] h;
        for (int s = 0; s < 9 + DW + 1; s++) begin
            if (s < 9)       h = delim_tb[s];
            else if (s < 9 + DW) h = d[DW-1-(s-9)] ? 2'b10 : 2'b01;
            else             h = 2'b00;
            for (int p = 0; p < BC; p++)
                exp_q.push_back({1'b1, (p < BC/2) ? h[1] : h[0], 1'b1, 1'b0});
        end
        exp_q.push_back(4'b0001);
    endtask

    task automatic step();
        logic [3:0] e;
        logic [3:0] o;
        @(posedge clk_24M);
        #1;
        if (exp_q.size() > 0) e = exp_q.pop_front();
        else                  e = 4'b0000;
        o = observed();
        line_samp.push_back(bus.line_out);
        checks++;
        assert (o === e) else begin
            errors++;
            $error("FAIL %s oe/line/busy/done observed=%b expected=%b", tag, o, e);
        end
    endtask

    task automatic drain();
        while (exp_q.size() > 0) step();
    endtask

    task automatic start_frame(input logic [DW-1:0] d);
        bus.tx_data  = d;
        bus.tx_start = 1'b1;
        push_frame(d);
        line_samp.delete();
        step();
        bus.tx_start = 1'b0;
        bus.tx_data  = ~d;
    endtask

    // Independent decoder: mid-first-half and mid-second-half samples of each data bit
    task automatic decode_check(input logic [DW-1:0] exp_d);
        logic [DW-1:0] got;
        logic          a, b;
        logic          q_ok;
        int            base;
        got  = '0;
        q_ok = 1'b1;
        for (int i = 0; i < DW; i++) begin
            base = (9 + i) * BC;
            a = line_samp[base + BC/4];
            b = line_samp[base + 3*BC/4];
            if (a == b) q_ok = 1'b0;
            got[DW-1-i] = a;
        end
        checks++;
        assert (got === exp_d) else begin
            errors++;
            $error("FAIL %s_decode observed=%h expected=%h", tag, got, exp_d);
        end
        checks++;
        assert (q_ok === 1'b1) else begin
            errors++;
            $error("FAIL %s_quality observed=%b expected=%b", tag, q_ok, 1'b1);
        end
    endtask

    initial begin
        logic [DW-1:0] d;
        bus.tx_start = 1'b0;
        bus.tx_data  = '0;
        rst          = 1'b1;
        repeat (3) @(posedge clk_24M);
        #1;
        checks++;
        assert (observed() === 4'b0000) else begin
            errors++;
            $error("FAIL reset observed=%b expected=%b", observed(), 4'b0000);
        end
        rst = 1'b0;

        tag = "idle";
        repeat (100) step();

        // Single frame with a mid-frame start that must be ignored
        tag = "single";
        start_frame(16'hA5C3);
        repeat (100) step();
        bus.tx_data  = 16'hFFFF;
        bus.tx_start = 1'b1;
        step();
        bus.tx_start = 1'b0;
        drain();
        decode_check(16'hA5C3);
        tag = "no_second";
        repeat (40) step();

        // Back-to-back: second start on the tx_done cycle
        tag = "b2b_first";
        start_frame(16'h1234);
        drain();
        tag = "b2b_second";
        start_frame(16'h0001);
        drain();
        decode_check(16'h0001);
        repeat (5) step();

        // Asynchronous reset mid-frame, then a normal frame
        tag = "pre_reset";
        start_frame(16'h5A5A);
        repeat (199) step();
        rst = 1'b1;
        #1;
        checks++;
        assert (observed() === 4'b0000) else begin
            errors++;
            $error("FAIL rst_async observed=%b expected=%b", observed(), 4'b0000);
        end
        exp_q.delete();
        tag = "in_reset";
        repeat (2) step();
        rst = 1'b0;
        tag = "post_reset_idle";
        repeat (2) step();
        tag = "post_reset";
        start_frame(16'h3C96);
        drain();
        decode_check(16'h3C96);

        // Loopback of random words
        tag = "loopback";
        for (int k = 0; k < 8; k++) begin
            d = DW'($urandom);
            start_frame(d);
            drain();
            decode_check(d);
            step();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
